// File: rtl/maze_pkg.sv
// maze_pkg: shared maze geometry, cell codes and arbiter state encoding
package maze_pkg;
    localparam int MAZE_AW = 6;
    localparam int MAZE_DW = 2;
    localparam logic [MAZE_DW-1:0] CELL_PATH   = 2'b00;
    localparam logic [MAZE_DW-1:0] CELL_WALL   = 2'b01;
    localparam logic [MAZE_DW-1:0] CELL_PLAYER = 2'b10;
    localparam logic [MAZE_DW-1:0] CELL_EXIT   = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_ACK
    } arb_state_t;
endpackage

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: shares the single-port maze memory between the game controller and display scanner
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int AW          = MAZE_AW,
    parameter int DW          = MAZE_DW,
    parameter int RD_LAT      = 1,
    parameter int C_BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int BCW = $clog2(C_BURST_MAX + 1);

    arb_state_t     r_state;
    logic           r_owner_d;
    logic           r_err;
    logic [WCW-1:0] r_wait;
    logic [BCW-1:0] r_burst;
    logic           w_burst_full;
    logic           w_grant_c;

    assign w_burst_full = (r_burst == BCW'(C_BURST_MAX));
    assign w_grant_c    = c_req && !(d_req && w_burst_full);
    assign busy         = (r_state != ST_IDLE);

    // Access sequencer: arbitrate in IDLE, drive memory in ACCESS, wait out read latency, pulse ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner_d <= 1'b0;
            r_err     <= 1'b0;
            r_wait    <= '0;
            r_burst   <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            c_ack     <= 1'b0;
            c_err     <= 1'b0;
            c_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            c_ack <= 1'b0;
            c_err <= 1'b0;
            d_ack <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!d_req) r_burst <= '0;
                    if (w_grant_c) begin
                        r_state   <= ST_ACCESS;
                        r_owner_d <= 1'b0;
                        mem_addr  <= c_addr;
                        mem_wdata <= c_wdata;
                        mem_we    <= c_we && !freeze;
                        r_err     <= c_we && freeze;
                        if (d_req && !w_burst_full) r_burst <= r_burst + BCW'(1);
                    end else if (d_req) begin
                        r_state   <= ST_ACCESS;
                        r_owner_d <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= 1'b0;
                        r_err     <= 1'b0;
                        r_burst   <= '0;
                    end
                end
                ST_ACCESS: begin
                    mem_we  <= 1'b0;
                    r_wait  <= WCW'(RD_LAT - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= ST_ACK;
                        if (r_owner_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_rdata;
                        end else begin
                            c_ack   <= 1'b1;
                            c_err   <= r_err;
                            c_rdata <= mem_rdata;
                        end
                    end else begin
                        r_wait <= r_wait - WCW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// tb_maze_mem_arbiter: scoreboard bench with a registered-read memory model behind the arbiter
module tb_maze_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freeze = 1'b0;
    logic       c_req = 1'b0, c_we = 1'b0;
    logic [5:0] c_addr = '0;
    logic [1:0] c_wdata = '0;
    logic       c_ack, c_err;
    logic [1:0] c_rdata;
    logic       d_req = 1'b0;
    logic [5:0] d_addr = '0;
    logic       d_ack;
    logic [1:0] d_rdata;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic       busy;

    typedef struct packed {
        logic       port_d;
        logic       err;
        logic       chk_data;
        logic [1:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] mem [64];
    logic [1:0] ref_mem [64];
    int         n_chk = 0;
    int         n_fail = 0;

    maze_mem_arbiter dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port memory, one cycle read latency, preset to a known pattern while in reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 2'(i);
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every ack pops the next expected completion
    always @(negedge clk) begin
        if (!rst && (c_ack || d_ack)) begin
            check("single_ack", {31'd0, c_ack & d_ack}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, c_ack, d_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", {31'd0, d_ack}, {31'd0, e.port_d});
                if (c_ack) check("c_err", {31'd0, c_err}, {31'd0, e.err});
                if (e.chk_data) check("rdata", {30'd0, d_ack ? d_rdata : c_rdata}, {30'd0, e.data});
            end
        end
    end

    task automatic run_c(input logic we, input logic [5:0] a, input logic [1:0] wd);
        int k, nwe;
        @(negedge clk);
        check("c_idle_busy", {31'd0, busy}, 32'd0);
        sb.push_back('{1'b0, we & freeze, !we, ref_mem[a]});
        if (we && !freeze) ref_mem[a] = wd;
        c_we = we; c_addr = a; c_wdata = wd; c_req = 1'b1;
        k = 0; nwe = 0;
        do begin
            @(negedge clk);
            k++;
            nwe += int'(mem_we);
            if (k == 1) check("c_mem_addr", {26'd0, mem_addr}, {26'd0, a});
            if (k <= 3) check("c_busy", {31'd0, busy}, 32'd1);
        end while (!c_ack && k < 20);
        c_req = 1'b0;
        check("c_latency", k, 3);
        check("c_we_cycles", nwe, (we && !freeze) ? 1 : 0);
    endtask

    task automatic run_d(input logic [5:0] a);
        int k, nwe;
        @(negedge clk);
        check("d_idle_busy", {31'd0, busy}, 32'd0);
        sb.push_back('{1'b1, 1'b0, 1'b1, ref_mem[a]});
        d_addr = a; d_req = 1'b1;
        k = 0; nwe = 0;
        do begin
            @(negedge clk);
            k++;
            nwe += int'(mem_we);
            if (k == 1) check("d_mem_addr", {26'd0, mem_addr}, {26'd0, a});
        end while (!d_ack && k < 20);
        d_req = 1'b0;
        check("d_latency", k, 3);
        check("d_we_cycles", nwe, 0);
    endtask

    initial begin
        int k, nd, nc;
        for (int i = 0; i < 64; i++) ref_mem[i] = 2'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {24'd0, c_ack, c_err, d_ack, mem_we, busy, c_rdata, d_rdata[0]}, 32'd0);
        check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        rst = 1'b0;

        // Reset while the write is on the memory bus: nothing acked, write strobe drops at once
        @(negedge clk);
        sb.push_back('{1'b0, 1'b0, 1'b0, 2'b00});
        c_we = 1'b1; c_addr = 6'd20; c_wdata = 2'b11; c_req = 1'b1;
        @(negedge clk);
        check("t1_we_access", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("t1_busy_rst", {31'd0, busy}, 32'd0);
        check("t1_we_rst", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("t1_no_ack", {30'd0, c_ack, d_ack}, 32'd0);
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!c_ack && k < 20);
        c_req = 1'b0;
        check("t1_regrant_latency", k, 3);
        ref_mem[20] = 2'b11;
        run_d(6'd20);

        run_c(1'b0, 6'd9, 2'b00);
        run_c(1'b1, 6'd12, 2'b10);
        run_d(6'd12);
        freeze = 1'b1;
        run_c(1'b1, 6'd12, 2'b11);
        run_c(1'b0, 6'd12, 2'b00);
        run_d(6'd12);
        freeze = 1'b0;
        run_c(1'b1, 6'd40, 2'b01);
        run_c(1'b0, 6'd40, 2'b00);

        // Both ports saturating the arbiter: four C grants then one D, twice
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) sb.push_back('{1'b0, 1'b0, 1'b1, ref_mem[9]});
            sb.push_back('{1'b1, 1'b0, 1'b1, ref_mem[12]});
        end
        c_we = 1'b0; c_addr = 6'd9; c_req = 1'b1;
        d_addr = 6'd12; d_req = 1'b1;
        k = 0; nd = 0; nc = 0;
        do begin
            @(negedge clk);
            k++;
            nd += int'(d_ack);
            nc += int'(c_ack);
        end while (nd < 2 && k < 100);
        c_req = 1'b0; d_req = 1'b0;
        check("t5_d_grants", nd, 2);
        check("t5_c_grants", nc, 8);

        // C holds its request through the IDLE cycle after ack: a second transaction follows
        @(negedge clk);
        @(negedge clk);
        sb.push_back('{1'b0, 1'b0, 1'b1, ref_mem[9]});
        sb.push_back('{1'b0, 1'b0, 1'b1, ref_mem[9]});
        c_we = 1'b0; c_addr = 6'd9; c_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!c_ack && k < 20);
        check("t6_lat1", k, 3);
        @(negedge clk);
        @(negedge clk);
        c_req = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!c_ack && k < 20);
        check("t6_lat2", k, 2);

        repeat (6) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("final_idle", {31'd0, busy}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
